// File: rtl/mul_pkg.sv
// Shared definitions for the multiplier issue front end: op encodings, FSM states and the
// product word selector.
package mul_pkg;

   localparam logic [1:0] MUL_W   = 2'b00;
   localparam logic [1:0] MULH_W  = 2'b01;
   localparam logic [1:0] MULH_WU = 2'b10;
   localparam logic [1:0] MUL_WU  = 2'b11;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StIssue = 3'd1,
      StWait  = 3'd2,
      StResp  = 3'd3,
      StDrain = 3'd4
   } mul_state_e;

   // High product word for MULH.W / MULH.WU, low word otherwise.
   function automatic logic sel_hi(input logic [1:0] op);
      return op[0] ^ op[1];
   endfunction

endpackage

// File: rtl/mul_issue_ctrl.sv
// EX-stage front end for the 32x32 multiplier: accepts one request, launches it, selects the
// result word and returns it with its tag; handles flush and multiplier timeout.
module mul_issue_ctrl
   import mul_pkg::*;
#(
   parameter int unsigned TAG_W   = 5,
   parameter int unsigned MAX_LAT = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_op,
   input  logic [31:0]      in_src1,
   input  logic [31:0]      in_src2,
   input  logic [TAG_W-1:0] in_tag,
   input  logic             flush,
   output logic             mul_req,
   output logic [31:0]      mul_x,
   output logic [31:0]      mul_y,
   output logic             mul_signed,
   input  logic             mul_done,
   input  logic [63:0]      mul_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             busy,
   output logic             err_timeout
);

   localparam int unsigned CntW = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;

   mul_state_e      state_q, state_d;
   logic [1:0]      op_q;
   logic [CntW-1:0] lat_cnt_q;
   logic            lat_hit;
   logic            timeout;
   logic            accept;

   assign lat_hit = (lat_cnt_q == CntW'(MAX_LAT - 1));
   assign accept  = in_valid && in_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      timeout = 1'b0;
      unique case (state_q)
         StIdle:  if (accept) state_d = StIssue;
         StIssue: state_d = flush ? StDrain : StWait;
         StWait: begin
            if (mul_done) begin
               state_d = flush ? StIdle : StResp;
            end else if (lat_hit) begin
               state_d = StIdle;
               timeout = 1'b1;
            end else if (flush) begin
               state_d = StDrain;
            end
         end
         // Flush wins over out_ready: nothing is delivered.
         StResp:  if (flush || out_ready) state_d = StIdle;
         StDrain: begin
            if (mul_done) begin
               state_d = StIdle;
            end else if (lat_hit) begin
               state_d = StIdle;
               timeout = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == StIdle) && !flush;
      out_valid = (state_q == StResp);
      busy      = (state_q != StIdle);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q        <= MUL_W;
         mul_x       <= '0;
         mul_y       <= '0;
         mul_signed  <= 1'b0;
         mul_req     <= 1'b0;
         out_data    <= '0;
         out_tag     <= '0;
         lat_cnt_q   <= '0;
         err_timeout <= 1'b0;
      end else begin
         mul_req     <= (state_d == StIssue);
         err_timeout <= err_timeout | timeout;
         if (accept) begin
            op_q       <= in_op;
            mul_x      <= in_src1;
            mul_y      <= in_src2;
            mul_signed <= ~in_op[1];
            out_tag    <= in_tag;
         end
         if (state_q == StIssue) begin
            lat_cnt_q <= '0;
         end else if (state_q == StWait || state_q == StDrain) begin
            lat_cnt_q <= lat_cnt_q + 1'b1;
         end
         if (state_q == StWait && mul_done && !flush) begin
            out_data <= sel_hi(op_q) ? mul_result[63:32] : mul_result[31:0];
         end
      end
   end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Randomized self-checking bench for mul_issue_ctrl with a behavioural multiplier model.
module tb_mul_issue_ctrl;

   localparam int TAG_W   = 5;
   localparam int MAX_LAT = 64;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [1:0]       in_op = 2'b00;
   logic [31:0]      in_src1 = '0;
   logic [31:0]      in_src2 = '0;
   logic [TAG_W-1:0] in_tag = '0;
   logic             flush = 1'b0;
   logic             mul_req;
   logic [31:0]      mul_x;
   logic [31:0]      mul_y;
   logic             mul_signed;
   logic             mul_done = 1'b0;
   logic [63:0]      mul_result = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [31:0]      out_data;
   logic [TAG_W-1:0] out_tag;
   logic             busy;
   logic             err_timeout;

   int n_vec = 0;
   int n_err = 0;
   int lat = 6;
   bit hang = 1'b0;

   mul_issue_ctrl #(.TAG_W(TAG_W), .MAX_LAT(MAX_LAT)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag), .flush(flush),
      .mul_req(mul_req), .mul_x(mul_x), .mul_y(mul_y), .mul_signed(mul_signed),
      .mul_done(mul_done), .mul_result(mul_result), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag), .busy(busy),
      .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] product(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
      longint sa, sb;
      longint unsigned ua, ub;
      if (s) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
         return 64'(sa * sb);
      end
      ua = 64'(a);
      ub = 64'(b);
      return ua * ub;
   endfunction

   // Multiplier model: done pulses lat cycles after the cycle mul_req is seen.
   logic [31:0] m_x, m_y;
   logic        m_s, m_busy;
   int          m_cnt;
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy   <= 1'b0;
         m_cnt    <= 0;
         mul_done <= 1'b0;
      end else begin
         mul_done <= 1'b0;
         if (mul_req && !hang) begin
            m_busy <= 1'b1;
            m_cnt  <= lat - 1;
            m_x    <= mul_x;
            m_y    <= mul_y;
            m_s    <= mul_signed;
         end else if (m_busy) begin
            if (m_cnt == 0) begin
               mul_done   <= 1'b1;
               mul_result <= product(m_x, m_y, m_s);
               m_busy     <= 1'b0;
            end else begin
               m_cnt <= m_cnt - 1;
            end
         end
      end
   end

   function automatic logic [31:0] ref_word(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
      logic [63:0] p;
      p = product(a, b, (op == 2'b00) || (op == 2'b01));
      return (op == 2'b01 || op == 2'b10) ? p[63:32] : p[31:0];
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag);
      bit ok;
      ok = 1'b0;
      in_valid = 1'b1;
      in_op = op;
      in_src1 = a;
      in_src2 = b;
      in_tag = tag;
      for (int i = 0; i < 200 && !ok; i++) begin
         if (in_ready) ok = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      check("accept", 64'(ok), 64'd1);
      check("issue_req", {62'd0, mul_req, mul_signed}, {62'd0, 1'b1, ~op[1]});
      check("issue_operands", {mul_x, mul_y}, {a, b});
   endtask

   task automatic txn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag, input int bp);
      int cycles;
      logic [31:0] exp;
      exp = ref_word(op, a, b);
      send(op, a, b, tag);
      tick();
      cycles = 1;
      check("req_one_cycle", 64'(mul_req), 64'd0);
      while (!out_valid && cycles < MAX_LAT + 20) begin
         tick();
         cycles++;
      end
      check("resp_latency", 64'(cycles), 64'(lat + 2));
      check("resp_data_tag", {27'd0, out_tag, out_data}, {27'd0, tag, exp});
      check("resp_operands_held", {mul_x, mul_y}, {a, b});
      for (int i = 0; i < bp; i++) begin
         tick();
         check("bp_stable", {29'd0, out_valid, in_ready, busy, out_data},
               {29'd0, 1'b1, 1'b0, 1'b1, exp});
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("handshake_done", {61'd0, out_valid, busy, in_ready}, {61'd0, 3'b001});
   endtask

   initial begin
      int cnt;
      bit seen_ov, prev_done;
      logic [1:0] op;
      logic [31:0] a, b;

      reset = 1'b1;
      repeat (2) tick();
      check("reset_ctrl", {58'd0, in_ready, mul_req, out_valid, err_timeout, busy, mul_signed},
            {58'd0, 6'b100000});
      check("reset_regs", {mul_x, out_data}, 64'd0);
      check("reset_regs2", {27'd0, out_tag, mul_y}, 64'd0);
      reset = 1'b0;
      tick();

      lat = 6;
      txn(2'b00, 32'd7, 32'hFFFF_FFFD, 5'd9, 0);
      txn(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd17, 1);
      txn(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd30, 0);
      txn(2'b11, 32'hFFFF_FFFF, 32'h0000_0003, 5'd4, 10);

      // Flush in WAIT two cycles after issue: drain, then no result.
      send(2'b00, 32'd11, 32'd13, 5'd1);
      tick();
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("drain_busy", 64'(busy), 64'd1);
      seen_ov = 1'b0;
      prev_done = 1'b0;
      cnt = 0;
      while (busy && cnt < MAX_LAT + 10) begin
         prev_done = mul_done;
         if (out_valid) seen_ov = 1'b1;
         tick();
         cnt++;
      end
      check("drain_no_output", 64'(seen_ov | out_valid), 64'd0);
      check("drain_exit_on_done", {62'd0, busy, prev_done}, {62'd0, 2'b01});
      txn(2'b01, 32'hFFFF_FFFE, 32'd5, 5'd2, 0);

      // Flush coincident with mul_done.
      send(2'b00, 32'd2, 32'd3, 5'd3);
      cnt = 0;
      while (!mul_done && cnt < 50) begin
         tick();
         cnt++;
      end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush_done_idle", {62'd0, busy, out_valid}, 64'd0);
      tick();
      tick();
      check("flush_done_quiet", {62'd0, busy, out_valid}, 64'd0);

      // Multiplier never completes.
      hang = 1'b1;
      send(2'b00, 32'd1, 32'd1, 5'd5);
      cnt = 0;
      while (busy && cnt < MAX_LAT + 20) begin
         tick();
         cnt++;
      end
      check("timeout_cycles", 64'(cnt), 64'(MAX_LAT + 1));
      check("timeout_flags", {61'd0, err_timeout, in_ready, out_valid}, {61'd0, 3'b110});
      hang = 1'b0;
      tick();
      txn(2'b10, 32'd100, 32'd200, 5'd6, 2);
      check("timeout_sticky", 64'(err_timeout), 64'd1);

      for (int i = 0; i < 40; i++) begin
         op = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0:       a = 32'h8000_0000;
            1:       a = 32'hFFFF_FFFF;
            default: a = $urandom;
         endcase
         b = ($urandom_range(0, 4) == 0) ? 32'h8000_0000 : $urandom;
         lat = $urandom_range(1, 8);
         txn(op, a, b, 5'($urandom), $urandom_range(0, 3));
      end

      // Async reset in the middle of WAIT.
      lat = 6;
      send(2'b01, 32'd9, 32'd9, 5'd7);
      tick();
      tick();
      reset = 1'b1;
      #1;
      check("async_reset_ctrl",
            {58'd0, in_ready, mul_req, out_valid, err_timeout, busy, mul_signed},
            {58'd0, 6'b100000});
      check("async_reset_regs", {mul_x, mul_y}, 64'd0);
      check("async_reset_out", {27'd0, out_tag, out_data}, 64'd0);
      tick();
      reset = 1'b0;
      tick();
      txn(2'b00, 32'd3, 32'd5, 5'd8, 0);
      check("post_reset_err", 64'(err_timeout), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mul_issue_ctrl.md
Name: mul_issue_ctrl

Overview:
- EX-stage front end for the pipelined Booth/Wallace 32x32 multiplier.
- Accepts MUL.W / MULH.W / MULH.WU requests from the execute pipeline over a valid/ready handshake and launches one multiply on the multiplier's `mult`/`done` interface.
- Selects the architecturally required 32-bit word of the 64-bit product and returns it, with its destination tag, over a second valid/ready handshake.
- Handles pipeline flush of an in-flight multiply, and flags a multiplier that never completes.

Parameters:
- TAG_W, 5, width of the destination-register tag carried with each request.
- MAX_LAT, 64, number of cycles in WAIT/DRAIN before a timeout is declared; minimum 8.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_op  in  2  00 MUL.W (low word, signed); 01 MULH.W (high word, signed); 10 MULH.WU (high word, unsigned); 11 low word, unsigned.
- in_src1  in  32  multiplicand.
- in_src2  in  32  multiplier.
- in_tag  in  TAG_W  destination tag.
- flush  in  1  cancel any request not yet delivered.
- mul_req  out  1  connects to multiplier `mult`.
- mul_x  out  32  connects to multiplier `x_in`.
- mul_y  out  32  connects to multiplier `y_in`.
- mul_signed  out  1  connects to multiplier `signed_op`.
- mul_done  in  1  multiplier done.
- mul_result  in  64  multiplier `result_out`.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- out_data  out  32  selected result word.
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  state != IDLE.
- err_timeout  out  1  sticky; set on timeout.

Behaviour:
- Reset (async): state=IDLE.
  - Outputs: in_ready=1, mul_req=0, out_valid=0, err_timeout=0.
  - Registers: out_data=0, out_tag=0, mul_x=0, mul_y=0, mul_signed=0, lat_cnt=0.
- States: IDLE, ISSUE, WAIT, RESP, DRAIN.
- IDLE:
  - in_ready = ~flush.
  - On accept: latch op, src1 into mul_x, src2 into mul_y, tag; mul_signed = ~op[1]. Go to ISSUE.
- ISSUE:
  - mul_req=1 for exactly this one cycle (registered output). lat_cnt cleared.
  - Next state is WAIT, or DRAIN if flush is high in this cycle.
- WAIT:
  - mul_x, mul_y and mul_signed are held stable; lat_cnt increments each cycle.
  - On mul_done: capture out_data = op[0]^op[1] ? mul_result[63:32] : mul_result[31:0]. This means hi word for ops 01/10, lo word for 00/11. Go to RESP.
  - flush without mul_done: go to DRAIN.
  - flush and mul_done in the same cycle: result discarded, go to IDLE.
- RESP:
  - out_valid=1; out_data and out_tag are stable until the handshake completes.
  - out_ready: go to IDLE.
  - flush: out_valid drops the next cycle, go to IDLE (flush has priority over out_ready in the same cycle; no delivery).
- DRAIN:
  - The multiplier cannot be aborted, so operands are held and lat_cnt keeps counting.
  - On mul_done: go to IDLE with no output.
  - A further flush has no effect.
- Timeout: in WAIT or DRAIN, when lat_cnt == MAX_LAT-1 with no mul_done, set err_timeout (sticky until reset), go to IDLE, drop the request.
- mul_done in IDLE, ISSUE or RESP is ignored.
- Throughput: one request in flight. Minimum request-to-out_valid latency is 2 cycles plus the multiplier latency.
- No new request is accepted in the cycle out_valid handshakes (IDLE is re-entered first).
- Reset mid-operation returns to IDLE immediately. The multiplier shares the same reset, so no drain is required.

Decomposition:
- Shared package `mul_pkg`:
  - op encoding localparams: MUL_W=2'b00, MULH_W=2'b01, MULH_WU=2'b10, MUL_WU=2'b11.
  - state encoding localparams.
  - helper function `sel_hi(op)`.
- No sub-module needed. The latency counter is inline.
- Top-level integration instantiates this block next to the multiplier.

Test Plan:
- Bench uses a behavioural multiplier model with configurable latency, default 6.
- MUL.W, src1=7, src2=0xFFFFFFFD -> mul_signed=1, one-cycle mul_req, out_data=0xFFFFFFEB, out_tag echoed.
- MULH.W, 0x80000000 × 0x80000000 -> out_data=0x40000000. MULH.WU, 0xFFFFFFFF × 0xFFFFFFFF -> mul_signed=0, out_data=0xFFFFFFFE.
- Backpressure: hold out_ready=0 for 10 cycles in RESP -> out_valid and out_data stable and in_ready=0 throughout; the handshake completes on the first out_ready.
- Flush cases:
  - flush in WAIT, 2 cycles after issue -> DRAIN, no out_valid, busy until mul_done, then a new request is accepted and correct.
  - flush coincident with mul_done -> IDLE, no output.
- Timeout: model never asserts done -> err_timeout rises after MAX_LAT cycles in WAIT, state IDLE, in_ready=1. err_timeout stays set through later normal requests until reset.
- Async reset asserted mid-WAIT -> all outputs at reset values in the same cycle. After deassertion, a MUL.W 3×5 returns 15.
